// File: rtl/rx_backend.sv
// rx_backend: UART receive back-end. Decodes raw frames against the live
// frame configuration, flags parity/framing errors, and queues
// {fe, pe, data} entries in a circular FIFO with a sticky overrun flag.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   cr_ds_i, cr_p_i, cr_s_i data size / parity mode / stop bits
//   packet_i, packet_valid_i raw frame (start bit stripped) and strobe
//   rx_read_i               pop head entry
//   rx_overrun_clear_i      clear sticky overrun
//   rx_valid_o              FIFO non-empty
//   rx_data_o/pe_o/fe_o     combinational view of head entry
//   rx_count_o              occupied entries
//   rx_overrun_o            sticky: a frame was dropped while full
module rx_backend #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cr_ds_i,
    input  logic [1:0]                   cr_p_i,
    input  logic                         cr_s_i,
    input  logic [10:0]                  packet_i,
    input  logic                         packet_valid_i,
    input  logic                         rx_read_i,
    input  logic                         rx_overrun_clear_i,
    output logic                         rx_valid_o,
    output logic [7:0]                   rx_data_o,
    output logic                         rx_pe_o,
    output logic                         rx_fe_o,
    output logic [$clog2(DEPTH+1)-1:0]   rx_count_o,
    output logic                         rx_overrun_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic       fe;
        logic       pe;
        logic [7:0] data;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_overrun;

    logic [7:0]      w_data;
    logic            w_par_en;
    logic            w_par_bit;
    logic            w_par_xor;
    logic [3:0]      w_stop_idx;
    logic            w_pe;
    logic            w_fe;
    logic            w_full;
    logic            w_empty;
    logic            w_wr;
    logic            w_rd;
    entry_t          w_entry;

    // Frame decode: data field, parity check and stop-bit check
    always_comb begin
        w_data = packet_i[7:0];
        if (cr_ds_i) begin
            w_data[7] = 1'b0;
        end
        w_par_en   = cr_p_i[1];
        w_par_bit  = cr_ds_i ? packet_i[7] : packet_i[8];
        // stop bits start right after the data field (and parity bit if present)
        w_stop_idx = (cr_ds_i ? 4'd7 : 4'd8) + 4'(w_par_en);
        // w_data[7] is already zero in 7-bit mode, so XOR-ing all 8 bits is exact
        w_par_xor  = (^w_data) ^ w_par_bit;
        w_pe       = w_par_en & (w_par_xor ^ cr_p_i[0]);
        w_fe       = ~packet_i[w_stop_idx] | (cr_s_i & ~packet_i[w_stop_idx + 4'd1]);
        w_entry    = '{fe: w_fe, pe: w_pe, data: w_data};
    end

    // FIFO control: a full FIFO still accepts a write when a read frees a slot
    always_comb begin
        w_full  = (r_count == CW'(DEPTH));
        w_empty = (r_count == '0);
        w_rd    = rx_read_i & ~w_empty;
        w_wr    = packet_valid_i & (~w_full | rx_read_i);
    end

    // Storage array, intentionally not reset
    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // Pointers, occupancy and sticky overrun
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // set has priority over clear
            if (packet_valid_i & ~w_wr) begin
                r_overrun <= 1'b1;
            end else if (rx_overrun_clear_i) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Head view and status outputs
    always_comb begin
        rx_valid_o   = ~w_empty;
        rx_data_o    = r_mem[r_rd_ptr].data;
        rx_pe_o      = r_mem[r_rd_ptr].pe;
        rx_fe_o      = r_mem[r_rd_ptr].fe;
        rx_count_o   = r_count;
        rx_overrun_o = r_overrun;
    end

endmodule

// File: tb/tb_rx_backend.sv
// tb_rx_backend: directed self-checking bench for rx_backend.
module tb_rx_backend;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cr_ds_i = 1'b0;
    logic [1:0]  cr_p_i = 2'b00;
    logic        cr_s_i = 1'b0;
    logic [10:0] packet_i = '0;
    logic        packet_valid_i = 1'b0;
    logic        rx_read_i = 1'b0;
    logic        rx_overrun_clear_i = 1'b0;
    logic        rx_valid_o;
    logic [7:0]  rx_data_o;
    logic        rx_pe_o;
    logic        rx_fe_o;
    logic [3:0]  rx_count_o;
    logic        rx_overrun_o;

    int checks = 0;
    int errors = 0;
    logic [7:0] q[$];

    always #5 clk_i = ~clk_i;

    rx_backend #(.DEPTH(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cr_ds_i(cr_ds_i), .cr_p_i(cr_p_i), .cr_s_i(cr_s_i),
        .packet_i(packet_i), .packet_valid_i(packet_valid_i),
        .rx_read_i(rx_read_i), .rx_overrun_clear_i(rx_overrun_clear_i),
        .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o),
        .rx_pe_o(rx_pe_o), .rx_fe_o(rx_fe_o),
        .rx_count_o(rx_count_o), .rx_overrun_o(rx_overrun_o)
    );

    // One-cycle frame strobe; returns at the following negedge
    task automatic push(input logic [10:0] pkt, input logic ds, input logic [1:0] p, input logic s);
        @(negedge clk_i);
        cr_ds_i = ds; cr_p_i = p; cr_s_i = s;
        packet_i = pkt; packet_valid_i = 1'b1;
        @(negedge clk_i);
        packet_valid_i = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk_i);
        rx_read_i = 1'b1;
        @(negedge clk_i);
        rx_read_i = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rx_valid_o); end
        checks++; if (rx_count_o !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", rx_count_o); end
        checks++; if (rx_overrun_o !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", rx_overrun_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_8n1();
        push(11'h1A5, 1'b0, 2'b00, 1'b0);
        checks++; if (rx_valid_o !== 1'b1) begin errors++; $display("FAIL 8n1_valid got %b exp 1", rx_valid_o); end
        checks++; if ({rx_fe_o, rx_pe_o, rx_data_o} !== 10'h0A5) begin errors++; $display("FAIL 8n1_entry got %h exp 0a5", {rx_fe_o, rx_pe_o, rx_data_o}); end
        checks++; if (rx_count_o !== 4'd1) begin errors++; $display("FAIL 8n1_count got %0d exp 1", rx_count_o); end
        pop();
        checks++; if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL 8n1_pop_valid got %b exp 0", rx_valid_o); end
        checks++; if (rx_count_o !== 4'd0) begin errors++; $display("FAIL 8n1_pop_count got %0d exp 0", rx_count_o); end
    endtask

    task automatic test_7e1();
        push(11'h141, 1'b1, 2'b10, 1'b0);
        checks++; if ({rx_fe_o, rx_pe_o, rx_data_o} !== 10'h041) begin errors++; $display("FAIL 7e1_good got %h exp 041", {rx_fe_o, rx_pe_o, rx_data_o}); end
        pop();
        push(11'h1C1, 1'b1, 2'b10, 1'b0);
        checks++; if ({rx_fe_o, rx_pe_o, rx_data_o} !== 10'h141) begin errors++; $display("FAIL 7e1_bad got %h exp 141", {rx_fe_o, rx_pe_o, rx_data_o}); end
        pop();
    endtask

    task automatic test_8o2();
        push(11'h700, 1'b0, 2'b11, 1'b1);
        push(11'h500, 1'b0, 2'b11, 1'b1);
        push(11'h300, 1'b0, 2'b11, 1'b1);
        checks++; if (rx_count_o !== 4'd3) begin errors++; $display("FAIL 8o2_count got %0d exp 3", rx_count_o); end
        checks++; if ({rx_fe_o, rx_pe_o, rx_data_o} !== 10'h000) begin errors++; $display("FAIL 8o2_good got %h exp 000", {rx_fe_o, rx_pe_o, rx_data_o}); end
        pop();
        checks++; if ({rx_fe_o, rx_pe_o, rx_data_o} !== 10'h200) begin errors++; $display("FAIL 8o2_stop1 got %h exp 200", {rx_fe_o, rx_pe_o, rx_data_o}); end
        pop();
        checks++; if ({rx_fe_o, rx_pe_o, rx_data_o} !== 10'h200) begin errors++; $display("FAIL 8o2_stop2 got %h exp 200", {rx_fe_o, rx_pe_o, rx_data_o}); end
        pop();
        checks++; if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL 8o2_empty got %b exp 0", rx_valid_o); end
    endtask

    task automatic test_fill_overrun();
        for (int i = 1; i <= 9; i++) push({3'b001, 8'(i)}, 1'b0, 2'b00, 1'b0);
        checks++; if (rx_count_o !== 4'd8) begin errors++; $display("FAIL fill_count got %0d exp 8", rx_count_o); end
        checks++; if (rx_overrun_o !== 1'b1) begin errors++; $display("FAIL fill_overrun got %b exp 1", rx_overrun_o); end
        checks++; if (rx_valid_o !== 1'b1) begin errors++; $display("FAIL fill_valid got %b exp 1", rx_valid_o); end
        for (int i = 1; i <= 8; i++) begin
            checks++; if (rx_data_o !== 8'(i)) begin errors++; $display("FAIL fill_order[%0d] got %h exp %h", i, rx_data_o, 8'(i)); end
            pop();
        end
        checks++; if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL fill_drained got %b exp 0", rx_valid_o); end
        @(negedge clk_i); rx_overrun_clear_i = 1'b1;
        @(negedge clk_i); rx_overrun_clear_i = 1'b0;
        checks++; if (rx_overrun_o !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", rx_overrun_o); end
        // refill, then overrun coinciding with clear
        for (int i = 0; i < 8; i++) begin
            push({3'b001, 8'(8'h10 + i)}, 1'b0, 2'b00, 1'b0);
            q.push_back(8'(8'h10 + i));
        end
        @(negedge clk_i);
        packet_i = 11'h1EE; packet_valid_i = 1'b1; rx_overrun_clear_i = 1'b1;
        @(negedge clk_i);
        packet_valid_i = 1'b0; rx_overrun_clear_i = 1'b0;
        checks++; if (rx_overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_set_wins got %b exp 1", rx_overrun_o); end
        checks++; if (rx_count_o !== 4'd8) begin errors++; $display("FAIL ovr_full_count got %0d exp 8", rx_count_o); end
        @(negedge clk_i); rx_overrun_clear_i = 1'b1;
        @(negedge clk_i); rx_overrun_clear_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            checks++; if (rx_data_o !== q[0]) begin errors++; $display("FAIL b2b_head[%0d] got %h exp %h", k, rx_data_o, q[0]); end
            if (k > 0) begin
                checks++; if (rx_count_o !== 4'd8) begin errors++; $display("FAIL b2b_count[%0d] got %0d exp 8", k, rx_count_o); end
            end
            packet_i = {3'b001, 8'(8'h40 + k)};
            packet_valid_i = 1'b1; rx_read_i = 1'b1;
            void'(q.pop_front());
            q.push_back(8'(8'h40 + k));
        end
        @(negedge clk_i);
        packet_valid_i = 1'b0; rx_read_i = 1'b0;
        checks++; if (rx_count_o !== 4'd8) begin errors++; $display("FAIL b2b_final_count got %0d exp 8", rx_count_o); end
        checks++; if (rx_overrun_o !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b exp 0", rx_overrun_o); end
        while (q.size() > 0) begin
            checks++; if (rx_data_o !== q[0]) begin errors++; $display("FAIL b2b_drain got %h exp %h", rx_data_o, q[0]); end
            void'(q.pop_front());
            pop();
        end
        checks++; if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", rx_valid_o); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 9; i++) push({3'b001, 8'(8'h60 + i)}, 1'b0, 2'b00, 1'b0);
        for (int i = 0; i < 5; i++) pop();
        checks++; if (rx_count_o !== 4'd3 || rx_overrun_o !== 1'b1) begin errors++; $display("FAIL rst_pre got cnt %0d ovr %b exp 3 1", rx_count_o, rx_overrun_o); end
        #2 rst_i = 1'b1;
        #1;
        checks++; if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %b exp 0", rx_valid_o); end
        checks++; if (rx_count_o !== 4'd0) begin errors++; $display("FAIL rst_async_count got %0d exp 0", rx_count_o); end
        checks++; if (rx_overrun_o !== 1'b0) begin errors++; $display("FAIL rst_async_overrun got %b exp 0", rx_overrun_o); end
        @(negedge clk_i); rst_i = 1'b0;
        pop();
        checks++; if (rx_count_o !== 4'd0 || rx_valid_o !== 1'b0) begin errors++; $display("FAIL empty_read got cnt %0d vld %b exp 0 0", rx_count_o, rx_valid_o); end
        push(11'h155, 1'b0, 2'b00, 1'b0);
        checks++; if ({rx_fe_o, rx_pe_o, rx_data_o} !== 10'h055 || rx_count_o !== 4'd1) begin errors++; $display("FAIL post_rst_write got %h cnt %0d exp 055 1", {rx_fe_o, rx_pe_o, rx_data_o}, rx_count_o); end
    endtask

    initial begin
        #1;
        test_reset();
        test_8n1();
        test_7e1();
        test_8o2();
        test_fill_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
